// File: rtl/nor_logic_unit.sv
`timescale 1ns/1ps
// Registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT/PASS) with a
// valid/ready handshake, a 2-entry result FIFO and a saturating transfer counter.
module nor_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  input  logic             cnt_clr
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic             push, pop;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_r;
      always_comb begin
        bit_r = a[gi];
        case (op)
          3'b000:  bit_r = a[gi] & b[gi];
          3'b001:  bit_r = a[gi] | b[gi];
          3'b010:  bit_r = ~(a[gi] & b[gi]);
          3'b011:  bit_r = ~(a[gi] | b[gi]);
          3'b100:  bit_r = a[gi] ^ b[gi];
          3'b101:  bit_r = ~(a[gi] ^ b[gi]);
          3'b110:  bit_r = ~a[gi];
          default: bit_r = a[gi];
        endcase
      end
      assign res[gi] = bit_r;
    end
  endgenerate

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // The next head may be the entry being written on this very edge.
    head_nxt = (push && (wr_ptr_q == rd_ptr_d)) ? res : mem_q[rd_ptr_d];
    y_d      = y_q;
    if (count_d != 2'd0) y_d = head_nxt;
    y_zero_d = (y_d == '0);
    xfer_d   = xfer_q;
    if (pop && (xfer_q != '1)) xfer_d = xfer_q + 1'b1;
    if (cnt_clr) xfer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      y_q      <= '0;
      y_zero_q <= 1'b1;
      xfer_q   <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      y_q      <= y_d;
      y_zero_q <= y_zero_d;
      xfer_q   <= xfer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= res;
  end

  assign y        = y_q;
  assign y_zero   = y_zero_q;
  assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_nor_logic_unit.sv
`timescale 1ns/1ps
// Bench for nor_logic_unit: op table, directed corner sequences and a random
// run checked against a reference queue scoreboard.
module tb_nor_logic_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic        in_ready, y_zero, out_valid;
  logic [7:0]  y;
  logic [15:0] xfer_cnt;
  logic        u2_in_ready, u2_y_zero, u2_out_valid;
  logic [7:0]  u2_y;
  logic [1:0]  u2_xfer_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nor_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .y_zero(y_zero), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt), .cnt_clr(cnt_clr));

  nor_logic_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(u2_in_ready), .y(u2_y), .y_zero(u2_y_zero), .out_valid(u2_out_valid),
    .out_ready(out_ready), .xfer_cnt(u2_xfer_cnt), .cnt_clr(cnt_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
    case (o)
      3'd0: return x & w;
      3'd1: return x | w;
      3'd2: return ~(x & w);
      3'd3: return ~(x | w);
      3'd4: return x ^ w;
      3'd5: return ~(x ^ w);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Reference model: state reflects the DUT after the most recent rising edge.
  logic [7:0]  sb_q[$];
  logic [7:0]  y_exp = '0;
  logic [15:0] x1_exp = '0;
  logic [1:0]  x2_exp = '0;
  logic        m_push, m_pop;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_y = '0;
  bit          sb_en = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb_q.size() != 2));
      chk("y", 32'(y), 32'(y_exp));
      chk("y_zero", 32'(y_zero), 32'(y_exp == 8'h00));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(x1_exp));
      chk("xfer_cnt_w2", 32'(u2_xfer_cnt), 32'(x2_exp));
      if (prev_stall) chk("stall_hold", 32'(y), 32'(prev_y));
      prev_stall = out_valid && !out_ready && !rst;
      prev_y     = y;
    end
    if (rst) begin
      sb_q.delete();
      y_exp  = '0;
      x1_exp = '0;
      x2_exp = '0;
    end else begin
      m_push = in_valid && (sb_q.size() != 2);
      m_pop  = (sb_q.size() != 0) && out_ready;
      if (m_pop) begin
        void'(sb_q.pop_front());
        if (x1_exp != 16'hFFFF) x1_exp = x1_exp + 16'd1;
        if (x2_exp != 2'd3)     x2_exp = x2_exp + 2'd1;
      end
      if (m_push) sb_q.push_back(ref_op(op, a, b));
      if (cnt_clr) begin
        x1_exp = '0;
        x2_exp = '0;
      end
      if (sb_q.size() != 0) y_exp = sb_q[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] x0;
    logic [1:0]  w2_exp;
    tbl[0] = '{3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1};
    tbl[1] = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[2] = '{3'd2, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[3] = '{3'd3, 8'hF0, 8'h0F, 8'h00, 1'b1};
    tbl[4] = '{3'd4, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[5] = '{3'd5, 8'hF0, 8'h0F, 8'h00, 1'b1};
    tbl[6] = '{3'd6, 8'hF0, 8'h0F, 8'h0F, 1'b0};
    tbl[7] = '{3'd7, 8'hF0, 8'h0F, 8'hF0, 1'b0};

    // Reset
    tick(); tick();
    rst = 1'b0;
    sb_en = 1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y", 32'(y), 32'h00);
    chk("rst_y_zero", 32'(y_zero), 32'd1);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);

    // Op table, streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      tick();
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_y", 32'(y), 32'(tbl[i].y));
      chk("tbl_y_zero", 32'(y_zero), 32'(tbl[i].z));
    end
    in_valid = 1'b0;
    tick();

    // Fill under backpressure; third operand must be refused
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd3;
    a = 8'h00; b = 8'h00; tick();
    chk("stall1_y", 32'(y), 32'hFF);
    a = 8'h01; b = 8'h00; tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_y", 32'(y), 32'hFF);
    a = 8'hFF; b = 8'hFF; tick();
    chk("full_in_ready2", 32'(in_ready), 32'd0);
    tick();
    chk("full_y2", 32'(y), 32'hFF);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("drain_y_fe", 32'(y), 32'hFE);
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("empty_hold_y", 32'(y), 32'hFE);
    in_valid = 1'b1; tick();
    chk("third_y", 32'(y), 32'h00);
    chk("third_y_zero", 32'(y_zero), 32'd1);
    in_valid = 1'b0; tick();

    // Count held at 1 with simultaneous push and pop
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h55; tick();
    x0 = x1_exp;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i * 7 + 3); op = 3'(i); b = 8'(i);
      tick();
      chk("pp_out_valid", 32'(out_valid), 32'd1);
      chk("pp_in_ready", 32'(in_ready), 32'd1);
    end
    chk("pp_xfer", 32'(xfer_cnt), 32'(x0 + 16'd20));
    in_valid = 1'b0; tick();

    // Saturation of the 2-bit counter, then clear during a pop
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; op = 3'd7;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) in_valid = 1'b0;
      a = 8'(k);
      tick();
      w2_exp = (k == 1) ? 2'd0 : ((k - 1) > 3 ? 2'd3 : 2'(k - 1));
      chk("sat_xfer_w2", 32'(u2_xfer_cnt), 32'(w2_exp));
    end
    in_valid = 1'b1; tick();
    in_valid = 1'b0; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    chk("clr_xfer", 32'(xfer_cnt), 32'd0);
    chk("clr_xfer_w2", 32'(u2_xfer_cnt), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);

    // Reset while full and busy
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd6; a = 8'h3C;
    tick(); tick();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_y", 32'(y), 32'h00);
    chk("mid_rst_y_zero", 32'(y_zero), 32'd1);
    chk("mid_rst_xfer", 32'(xfer_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      cnt_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick(); tick();
    chk("final_empty", 32'(out_valid), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nor_logic_unit.md
Name: nor_logic_unit

Overview:
- Parametrised, registered successor to the two-input dataflow NOR gate.
- Performs a selectable bitwise logic operation (NOR default family: AND/OR/NAND/NOR/XOR/XNOR/NOT/PASS) on WIDTH-bit operands.
- Uses a valid/ready handshake and a 2-entry result buffer.
- Sits between an operand producer and a result consumer; keeps a transfer counter for bring-up visibility.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- CNT_W, 16, width of saturating output-transfer counter (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with a/b
- in_valid  input  1  a/b/op valid
- in_ready  output  1  block can accept operands this cycle
- y  output  WIDTH  result at buffer head
- y_zero  output  1  head result equals all zeros
- out_valid  output  1  y valid
- out_ready  input  1  consumer accepts y this cycle
- xfer_cnt  output  CNT_W  number of output transfers since reset/clear
- cnt_clr  input  1  synchronous clear of xfer_cnt

Behaviour:
- Operation select, bitwise over WIDTH bits:
  - 000 a&b
  - 001 a|b
  - 010 ~(a&b)
  - 011 ~(a|b)
  - 100 a^b
  - 101 ~(a^b)
  - 110 ~a (b ignored)
  - 111 a (pass, b ignored)
- Result is computed at acceptance and stored, so later changes on a/b/op do not affect buffered entries.
- Buffer:
  - 2-entry in-order FIFO with occupancy count 0..2.
  - out_valid = (count!=0).
  - in_ready = (count!=2), derived from registered count only; there is no combinational path from out_ready to in_ready.
- Transfers:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- Latency: operands pushed at edge k appear on y with out_valid=1 after edge k (cycle k+1) if the buffer was empty.
- Throughput: one result per cycle sustained when out_ready=1 continuously.
- Count transitions by (push, pop):
  - (1,0) count+1
  - (0,1) count-1
  - (1,1) count unchanged; head advances and the new entry is written behind it.
  - At count=1, a simultaneous push and pop makes the new result the head next cycle.
- Full (count=2): in_ready=0; in_valid is ignored; entries are held until popped.
- Empty (count=0):
  - out_valid=0.
  - y and y_zero hold their last values; the consumer must not sample them.
  - out_ready is ignored.
- Read/write pointers are 1 bit each and wrap 1->0.
- y_zero = (y == 0) on the head entry, registered with the entry, so it changes only with the head.
- Stalls: while out_valid=1 and out_ready=0, y and y_zero remain stable.
- xfer_cnt:
  - Increments by 1 on each pop.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces 0 on the next edge and takes precedence over a same-cycle increment.
- Reset (rst=1 at a rising edge), also when applied mid-operation:
  - count=0 and pointers=0; all buffered entries are discarded.
  - out_valid=0, in_ready=1 the cycle after reset, y=0, y_zero=1, xfer_cnt=0.
  - Reset overrides push, pop and clear in the same cycle.
- No X propagation from op: every op code is defined.

Test Plan:
- Reset then, with WIDTH=8, push a=8'hF0, b=8'h0F for each op 000..111 with out_ready=1 -> y sequence 00, FF, FF, 00, FF, 00, 0F, F0. Each result appears one cycle after push; y_zero=1 on the 00 results.
- Hold out_ready=0, push 3 back-to-back (NOR: a=00,b=00; a=01,b=00; a=FF,b=FF) -> third is not accepted, with in_ready=0 after two pushes and y stable at FF. Then raise out_ready -> FF, FE emerge in order. Re-presenting the third yields 00 with y_zero=1.
- count=1 with simultaneous push and pop for 20 cycles -> count stays 1, no loss or duplication, and xfer_cnt advances by 20.
- CNT_W=2: perform 5 pops -> xfer_cnt reads 1, 2, 3, 3, 3. Assert cnt_clr together with a pop -> xfer_cnt=0.
- With count=2, assert rst for one cycle while in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, y=0, y_zero=1, xfer_cnt=0, and no stale entry ever appears.
- Random in_valid/out_ready for 10k cycles against a reference queue model -> all results match in order, and out_valid&&!out_ready never shows y changing.
